// File: rtl/output_layer_writer.sv
// Output layer writer: drains the output FIFO into memory as one AXI4 INCR
// burst per row (layer outer, row inner), with a single burst outstanding.
module output_layer_writer #(
  parameter int C_S_AXI_ID_WIDTH   = 3,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   axi_address,
  input  logic [9:0]                      no_of_output_layers,
  input  logic [9:0]                      output_layer_row_size,
  input  logic [9:0]                      output_layer_col_size,
  output logic                            busy,
  output logic                            done,
  output logic                            cfg_err,
  output logic                            wr_err,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   out_fifo_data,
  input  logic [9:0]                      out_fifo_dcount,
  output logic                            out_fifo_rd_en,
  output logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_awid,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_axi_awaddr,
  output logic [7:0]                      M_axi_awlen,
  output logic [2:0]                      M_axi_awsize,
  output logic [1:0]                      M_axi_awburst,
  output logic                            M_axi_awlock,
  output logic [3:0]                      M_axi_awcache,
  output logic [2:0]                      M_axi_awprot,
  output logic [3:0]                      M_axi_awqos,
  output logic                            M_axi_awvalid,
  input  logic                            M_axi_awready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   M_axi_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_axi_wstrb,
  output logic                            M_axi_wlast,
  output logic                            M_axi_wvalid,
  input  logic                            M_axi_wready,
  input  logic [1:0]                      M_axi_bresp,
  input  logic                            M_axi_bvalid,
  output logic                            M_axi_bready
);

  // state     | meaning
  // IDLE      | waiting for start; config checked here
  // WAIT_DATA | waiting until the FIFO holds a full row
  // ADDR      | AW channel presented for the current row
  // DATA      | popping the row through the skid buffer onto W
  // RESP      | waiting for the B response of the row
  // DONE      | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_ADDR, S_DATA, S_RESP, S_DONE
  } state_t;

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;

  state_t state, state_nxt;

  logic [AW-1:0] base_q, awaddr_q;
  logic [9:0]    layers_q, rows_q, layer_cnt, row_cnt;
  logic [3:0]    beats_q, popped, sent;
  logic [1:0]    occ, occ_after;
  logic          inflight, pop, cfg_ok, last_row, last_layer;
  logic [DW-1:0] skid0, skid1;
  logic [3:0]    beats_in;

  assign beats_in   = 4'((output_layer_col_size + 10'd7) >> 3);
  assign cfg_ok     = (no_of_output_layers != 10'd0) &&
                      (output_layer_row_size != 10'd0) && (output_layer_row_size <= 10'd64) &&
                      (output_layer_col_size != 10'd0) && (output_layer_col_size <= 10'd64);
  assign last_row   = (row_cnt == rows_q - 10'd1);
  assign last_layer = (layer_cnt == layers_q - 10'd1);

  assign M_axi_awid    = '0;
  assign M_axi_awaddr  = awaddr_q;
  assign M_axi_awlen   = {4'd0, beats_q - 4'd1};
  assign M_axi_awsize  = 3'd3;
  assign M_axi_awburst = 2'b01;
  assign M_axi_awlock  = 1'b0;
  assign M_axi_awcache = 4'b0011;
  assign M_axi_awprot  = 3'd0;
  assign M_axi_awqos   = 4'd0;
  assign M_axi_wstrb   = '1;
  assign M_axi_wdata   = skid0;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    busy           = (state != S_IDLE);
    done           = (state == S_DONE);
    M_axi_awvalid  = (state == S_ADDR);
    M_axi_bready   = (state == S_RESP);
    M_axi_wvalid   = (state == S_DATA) && (occ != 2'd0);
    M_axi_wlast    = M_axi_wvalid && (sent == beats_q - 4'd1);
    pop            = M_axi_wvalid && M_axi_wready;
    // Occupancy as it will stand next cycle; lets a pop free a slot the
    // same cycle so the row streams at one beat per clock.
    occ_after      = occ - {1'b0, pop} + {1'b0, inflight};
    out_fifo_rd_en = (state == S_DATA) && (popped < beats_q) && (occ_after < 2'd2);

    case (state)
      S_IDLE:      if (start && cfg_ok) state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: if (out_fifo_dcount >= {6'd0, beats_q}) state_nxt = S_ADDR;
      S_ADDR:      if (M_axi_awready) state_nxt = S_DATA;
      S_DATA:      if (pop && M_axi_wlast) state_nxt = S_RESP;
      S_RESP:      if (M_axi_bvalid) state_nxt = (last_row && last_layer) ? S_DONE : S_WAIT_DATA;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q    <= '0;
      awaddr_q  <= '0;
      layers_q  <= '0;
      rows_q    <= '0;
      beats_q   <= '0;
      layer_cnt <= '0;
      row_cnt   <= '0;
      popped    <= '0;
      sent      <= '0;
      occ       <= '0;
      inflight  <= 1'b0;
      skid0     <= '0;
      skid1     <= '0;
      cfg_err   <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        if (cfg_ok) begin
          base_q    <= axi_address;
          layers_q  <= no_of_output_layers;
          rows_q    <= output_layer_row_size;
          beats_q   <= beats_in;
          layer_cnt <= '0;
          row_cnt   <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      // Address is frozen once ADDR is entered, so it is stable until awready.
      if (state == S_WAIT_DATA)
        awaddr_q <= base_q + (AW'(layer_cnt) << 12) + (AW'(row_cnt) << 6);

      if (M_axi_bready && M_axi_bvalid) begin
        if (M_axi_bresp != 2'b00) wr_err <= 1'b1;
        if (last_row) begin
          row_cnt   <= '0;
          layer_cnt <= layer_cnt + 10'd1;
        end else begin
          row_cnt <= row_cnt + 10'd1;
        end
      end

      if (state != S_DATA) begin
        popped   <= '0;
        sent     <= '0;
        occ      <= '0;
        inflight <= 1'b0;
      end else begin
        inflight <= out_fifo_rd_en;
        occ      <= occ_after;
        if (out_fifo_rd_en) popped <= popped + 4'd1;
        if (pop)            sent   <= sent + 4'd1;
        case ({pop, inflight})
          2'b01: begin
            if (occ == 2'd0) skid0 <= out_fifo_data;
            else             skid1 <= out_fifo_data;
          end
          2'b10: skid0 <= skid1;
          2'b11: begin
            if (occ == 2'd1) begin
              skid0 <= out_fifo_data;
            end else begin
              skid0 <= skid1;
              skid1 <= out_fifo_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_output_layer_writer.sv
// Bench for output_layer_writer: FIFO/AXI slave models driven from a single
// bus process; expectations queued at stimulus time and popped on handshakes.
module tb_output_layer_writer;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start;
  logic [AW-1:0] axi_address;
  logic [9:0]    layers, rows, cols;
  logic          busy, done, cfg_err, wr_err;
  logic [DW-1:0] out_fifo_data;
  logic [9:0]    out_fifo_dcount;
  logic          out_fifo_rd_en;
  logic [IW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize, awprot;
  logic [1:0]    awburst, bresp;
  logic          awlock, awvalid, awready;
  logic [3:0]    awcache, awqos;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wlast, wvalid, wready, bvalid, bready;

  output_layer_writer #(
    .C_S_AXI_ID_WIDTH(IW), .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .axi_address(axi_address),
    .no_of_output_layers(layers), .output_layer_row_size(rows),
    .output_layer_col_size(cols), .busy(busy), .done(done), .cfg_err(cfg_err),
    .wr_err(wr_err), .out_fifo_data(out_fifo_data), .out_fifo_dcount(out_fifo_dcount),
    .out_fifo_rd_en(out_fifo_rd_en), .M_axi_awid(awid), .M_axi_awaddr(awaddr),
    .M_axi_awlen(awlen), .M_axi_awsize(awsize), .M_axi_awburst(awburst),
    .M_axi_awlock(awlock), .M_axi_awcache(awcache), .M_axi_awprot(awprot),
    .M_axi_awqos(awqos), .M_axi_awvalid(awvalid), .M_axi_awready(awready),
    .M_axi_wdata(wdata), .M_axi_wstrb(wstrb), .M_axi_wlast(wlast),
    .M_axi_wvalid(wvalid), .M_axi_wready(wready), .M_axi_bresp(bresp),
    .M_axi_bvalid(bvalid), .M_axi_bready(bready)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } aw_exp_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } w_exp_t;

  aw_exp_t       exp_aw_q[$];
  w_exp_t        exp_w_q[$];
  logic [DW-1:0] fifo_q[$];

  int n_pass = 0, n_total = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, rd_cnt = 0, cyc = 0, word_idx = 0;
  int dcount_force = -1, bad_burst = -1;
  bit toggle_wready = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  function automatic logic [DW-1:0] word_of(input int i);
    return {16'hC0DE, 16'(i), 32'(i) * 32'h9E37_79B9};
  endfunction

  task automatic add_burst(input logic [AW-1:0] addr, input int beats);
    aw_exp_t a;
    w_exp_t  w;
    a.addr = addr;
    a.len  = 8'(beats - 1);
    exp_aw_q.push_back(a);
    for (int b = 0; b < beats; b++) begin
      fifo_q.push_back(word_of(word_idx));
      w.data = word_of(word_idx);
      w.last = (b == beats - 1);
      exp_w_q.push_back(w);
      word_idx++;
    end
  endtask

  // FIFO + AXI slave models and the checking monitor.
  logic [DW-1:0] nxt_word, stall_data;
  logic [AW-1:0] stall_addr;
  bit ev_rd, ev_b, aw_open, b_wait, stalled, aw_stalled;
  int beat, last_w_cyc;
  initial begin : bfm
    aw_exp_t ea;
    w_exp_t  ew;
    out_fifo_data = '0; out_fifo_dcount = '0;
    awready = 1'b0; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    nxt_word = '0; stall_data = '0; stall_addr = '0;
    aw_open = 0; b_wait = 0; stalled = 0; aw_stalled = 0; beat = 0; last_w_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      ev_rd = 0;
      ev_b  = 0;
      if (!reset_n) begin
        fifo_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
        aw_open = 0; b_wait = 0; stalled = 0; aw_stalled = 0; beat = 0;
      end else begin
        if (out_fifo_rd_en) begin
          rd_cnt++;
          chk("rd_en_inside_burst", 64'(aw_open), 64'd1);
          chk("fifo_not_overread", 64'(fifo_q.size() != 0), 64'd1);
          if (fifo_q.size() != 0) begin
            nxt_word = fifo_q.pop_front();
            ev_rd = 1;
          end
        end
        if (awvalid) begin
          chk("aw_one_outstanding", 64'({aw_open, b_wait}), 64'd0);
          if (aw_stalled) chk("awaddr_stable", 64'(awaddr), 64'(stall_addr));
          if (awready) begin
            aw_cnt++;
            aw_open = 1;
            aw_stalled = 0;
            chk("aw_expected", 64'(exp_aw_q.size() != 0), 64'd1);
            chk("aw_constants", 64'({awid, awsize, awburst, awlock, awcache, awprot, awqos, wstrb}),
                64'({3'd0, 3'd3, 2'd1, 1'b0, 4'b0011, 3'd0, 4'd0, 8'hFF}));
            if (exp_aw_q.size() != 0) begin
              ea = exp_aw_q.pop_front();
              chk("awaddr", 64'(awaddr), 64'(ea.addr));
              chk("awlen", 64'(awlen), 64'(ea.len));
            end
          end else begin
            aw_stalled = 1;
            stall_addr = awaddr;
          end
        end
        if (wvalid) begin
          chk("wvalid_after_aw", 64'(aw_open), 64'd1);
          if (stalled) chk("wdata_stable", wdata, stall_data);
          if (wready) begin
            stalled = 0;
            w_cnt++;
            if (!toggle_wready && beat > 0) chk("w_full_rate", 64'(cyc), 64'(last_w_cyc + 1));
            last_w_cyc = cyc;
            chk("w_expected", 64'(exp_w_q.size() != 0), 64'd1);
            if (exp_w_q.size() != 0) begin
              ew = exp_w_q.pop_front();
              chk("wdata", wdata, ew.data);
              chk("wlast", 64'(wlast), 64'(ew.last));
            end
            beat++;
            if (wlast) begin
              aw_open = 0;
              b_wait  = 1;
              beat    = 0;
            end
          end else begin
            stalled = 1;
            stall_data = wdata;
          end
        end
        if (bvalid && bready) begin
          b_wait = 0;
          b_cnt++;
          ev_b = 1;
        end
      end
      @(posedge clk);
      #1;
      if (ev_rd) out_fifo_data = nxt_word;
      out_fifo_dcount = (dcount_force >= 0) ? 10'(dcount_force) : 10'(fifo_q.size());
      wready  = toggle_wready ? ~wready : 1'b1;
      awready = ~awready;
      if (!reset_n || ev_b) begin
        bvalid = 1'b0;
      end else if (b_wait && !bvalid) begin
        bvalid = 1'b1;
        bresp  = (b_cnt == bad_burst) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 64'(done), 64'd1);
    if (done === 1'b1) begin
      chk({name, "_busy_in_done"}, 64'(busy), 64'd1);
      tick();
      chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
      chk({name, "_idle_after_done"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic chk_drained(input string name);
    chk({name, "_drained"}, 64'(exp_aw_q.size() + exp_w_q.size() + fifo_q.size()), 64'd0);
  endtask

  logic [AW-1:0] t1_addr [6];
  initial begin : main
    int a0, r0, w0, n;
    t1_addr = '{32'h1000_0000, 32'h1000_0040, 32'h1000_0080,
                32'h1000_1000, 32'h1000_1040, 32'h1000_1080};
    reset_n = 1'b0; start = 1'b0; axi_address = '0;
    layers = '0; rows = '0; cols = '0;
    repeat (3) tick();
    chk("rst_controls", 64'({awvalid, wvalid, wlast, bready, out_fifo_rd_en, busy, done}), 64'd0);
    chk("rst_errors", 64'({cfg_err, wr_err}), 64'd0);
    chk("rst_awaddr", 64'(awaddr), 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    reset_n = 1'b1;
    tick();

    // 2 layers x 3 rows x 55 cols: 7 beats per row, awlen 6
    axi_address = 32'h1000_0000; layers = 10'd2; rows = 10'd3; cols = 10'd55;
    for (int i = 0; i < 6; i++) add_burst(t1_addr[i], 7);
    a0 = aw_cnt;
    pulse_start();
    wait_done("t1", 400);
    chk("t1_bursts", 64'(aw_cnt - a0), 64'd6);
    chk_drained("t1");

    // FIFO reports empty for 20 cycles: nothing may move
    axi_address = 32'h2000_0000; layers = 10'd1; rows = 10'd1; cols = 10'd8;
    dcount_force = 0;
    add_burst(32'h2000_0000, 1);
    a0 = aw_cnt; r0 = rd_cnt;
    pulse_start();
    repeat (20) tick();
    chk("t2_busy_waiting", 64'(busy), 64'd1);
    chk("t2_no_aw_while_empty", 64'(aw_cnt - a0 + int'(awvalid)), 64'd0);
    chk("t2_no_rd_while_empty", 64'(rd_cnt - r0), 64'd0);
    dcount_force = 1;
    wait_done("t2", 100);
    dcount_force = -1;
    chk("t2_bursts", 64'(aw_cnt - a0), 64'd1);
    chk_drained("t2");

    // 64 columns with wready toggling
    toggle_wready = 1'b1;
    axi_address = 32'h3000_0000; layers = 10'd1; rows = 10'd2; cols = 10'd64;
    add_burst(32'h3000_0000, 8);
    add_burst(32'h3000_0040, 8);
    r0 = rd_cnt;
    pulse_start();
    wait_done("t3", 400);
    toggle_wready = 1'b0;
    chk("t3_reads", 64'(rd_cnt - r0), 64'd16);
    chk_drained("t3");

    // error response on the second burst
    bad_burst = b_cnt + 1;
    axi_address = 32'h4000_0000; layers = 10'd1; rows = 10'd3; cols = 10'd16;
    add_burst(32'h4000_0000, 2);
    add_burst(32'h4000_0040, 2);
    add_burst(32'h4000_0080, 2);
    pulse_start();
    wait_done("t4", 300);
    bad_burst = -1;
    chk("t4_wr_err", 64'(wr_err), 64'd1);
    chk_drained("t4");
    repeat (5) tick();
    chk("t4_wr_err_sticky", 64'(wr_err), 64'd1);

    // illegal configs
    axi_address = 32'h5000_0000; layers = 10'd1; rows = 10'd1; cols = 10'd0;
    a0 = aw_cnt; r0 = rd_cnt;
    pulse_start();
    repeat (3) tick();
    chk("t5_cols0_cfg_err", 64'(cfg_err), 64'd1);
    chk("t5_cols0_idle", 64'(busy), 64'd0);
    chk("t5_wr_err_held", 64'(wr_err), 64'd1);
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("t5_errs_cleared", 64'({cfg_err, wr_err}), 64'd0);
    rows = 10'd65; cols = 10'd8;
    pulse_start();
    repeat (3) tick();
    chk("t5_rows65_cfg_err", 64'(cfg_err), 64'd1);
    chk("t5_rows65_idle", 64'(busy), 64'd0);
    chk("t5_no_axi", 64'(aw_cnt - a0 + rd_cnt - r0 + int'(awvalid)), 64'd0);

    // reset on the third W beat, then restart
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    axi_address = 32'h5000_0000; layers = 10'd1; rows = 10'd2; cols = 10'd64;
    add_burst(32'h5000_0000, 8);
    add_burst(32'h5000_0040, 8);
    w0 = w_cnt;
    pulse_start();
    n = 0;
    while (!(wvalid === 1'b1 && w_cnt - w0 == 3) && n < 100) begin
      tick();
      n++;
    end
    chk("t6_third_beat_reached", 64'(w_cnt - w0), 64'd3);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_quiet_after_reset", 64'({awvalid, wvalid, wlast, bready, out_fifo_rd_en, busy, done}), 64'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    add_burst(32'h5000_0000, 8);
    add_burst(32'h5000_0040, 8);
    a0 = aw_cnt;
    pulse_start();
    wait_done("t6", 300);
    chk("t6_bursts", 64'(aw_cnt - a0), 64'd2);
    chk_drained("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
